card_match_engine: RTL and testbench
====================================

Name: card_match_engine

Overview:
- Game-logic consumer of the 48-bit card map produced by the random pair generator: latches the map, accepts player flips one card index at a time, compares the two revealed symbols, and tracks matched cards, pair count, move count and win.
- Sits between the map generator (its `done` drives map_load) and the display/input front end.

Parameters:
- HOLD_CYCLES, 50000000, cycles a mismatched pair stays face-up before both cards are hidden again (min 1).
- MOVE_W, 8, width of the move counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- map_load  in  1  one-cycle pulse: latch map_in and start a new game.
- map_in  in  [0:47]  card i symbol = map_in[3*i +: 3] (bit 3*i is the MSB), i = 0..15.
- flip_valid  in  1  flip request strobe.
- flip_idx  in  4  card index being flipped.
- flip_accept  out  1  one-cycle pulse: flip taken.
- flip_reject  out  1  one-cycle pulse: flip ignored.
- face_up  out  16  bit i = card i currently shown (includes matched cards).
- matched  out  16  bit i = card i permanently matched.
- sym_a  out  3  symbol of the first revealed card.
- sym_b  out  3  symbol of the second revealed card.
- match_pulse  out  1  one-cycle pulse: the pair matched.
- mismatch_pulse  out  1  one-cycle pulse: the pair did not match.
- pair_count  out  4  matched pairs, 0..8.
- move_count  out  MOVE_W  completed comparisons; saturates at all-ones.
- game_won  out  1  high while in WIN.
- busy  out  1  high in COMPARE or SHOW.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including face_up, matched, counters and all pulses.
  - Latched map = 0, timer = 0.
- States and transitions:
  - IDLE: no map loaded. Every flip_valid gives flip_reject.
  - WAIT_FIRST: a legal flip sets face_up[idx], latches idx_a and sym_a, pulses flip_accept; next state WAIT_SECOND.
  - WAIT_SECOND: a legal flip sets face_up[idx], latches idx_b and sym_b, pulses flip_accept; next state COMPARE.
  - COMPARE: one cycle; move_count increments (saturating).
    - sym_a == sym_b: matched[idx_a] and matched[idx_b] set, pair_count+1, match_pulse. Go to WIN if pair_count was 7, else WAIT_FIRST.
    - Otherwise: mismatch_pulse, timer = HOLD_CYCLES-1, go to SHOW.
  - SHOW: timer decrements each cycle. In the cycle the timer is 0, face_up[idx_a] and face_up[idx_b] clear; next state WAIT_FIRST.
  - WIN: game_won = 1. Stays here until map_load or reset.
- Flip legality:
  - A flip is illegal if face_up[flip_idx] is already set. This covers matched cards and re-flipping card A as card B.
  - Flips in IDLE, COMPARE, SHOW and WIN are rejected.
  - Exactly one of flip_accept / flip_reject pulses, in the cycle after each flip_valid.
- Latency:
  - From the second accepted flip_valid to match_pulse/mismatch_pulse: 2 cycles.
  - Mismatched cards stay face-up for HOLD_CYCLES cycles after mismatch_pulse.
- map_load:
  - Accepted in any state. Clears face_up, matched, pair_count, move_count and the timer; latches map_in; next state WAIT_FIRST.
  - If flip_valid arrives in the same cycle, map_load wins and the flip is rejected.
- The block does not validate map pairing. An unpaired symbol simply never matches.
- sym_a and sym_b hold their last values until overwritten or map_load (cleared to 0).
- Reset mid-game aborts immediately to the reset values above.

Decomposition:
- Shared package (card_pkg):
  - NUM_CARDS = 16, SYM_W = 3, NUM_PAIRS = 8, IDX_W = 4.
  - State enumeration: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN.
- Sub-module hold_timer: load/countdown with a zero flag, width $clog2(HOLD_CYCLES). Instantiated once.

Test Plan (HOLD_CYCLES = 4 unless stated):
1. Reset, then flip_valid idx 3 with no map -> flip_reject; face_up = 0; game_won = 0.
2. Load a map with cards 0 and 5 both symbol 3'd6. Flip 0, then flip 5 -> 2 accepts, then match_pulse; matched = 16'h0021; pair_count = 1; move_count = 1.
3. Flip cards 1 and 2 with symbols 3'd1 and 3'd2 -> mismatch_pulse; busy high; face_up bits 1 and 2 stay set for exactly 4 cycles then clear; a flip during SHOW -> flip_reject.
4. Re-flip an already-matched card 0, and flip card A again as card B -> flip_reject both times; state and counters unchanged.
5. Match all 8 pairs -> pair_count = 8; game_won = 1; matched = 16'hFFFF; further flips rejected.
6. map_load with a simultaneous flip_valid during SHOW -> flip rejected; face_up = 0; counters = 0; state WAIT_FIRST. A subsequent reset during WAIT_SECOND returns all outputs to 0 in the next cycle.

Source files
------------

// File: rtl/card_match_engine_pkg.sv
// Shared constants, FSM state encoding and the card-symbol lookup for the
// card match engine.
package card_pkg;

  localparam int NUM_CARDS = 16;
  localparam int SYM_W     = 3;
  localparam int NUM_PAIRS = 8;
  localparam int IDX_W     = 4;
  localparam int PAIR_W    = 4;
  localparam int MAP_W     = NUM_CARDS * SYM_W;

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_FIRST  = 3'd1,
    WAIT_SECOND = 3'd2,
    COMPARE     = 3'd3,
    SHOW        = 3'd4,
    WIN         = 3'd5
  } card_state_e;

  // Card i occupies map[3*i +: 3]; the map is ascending, so bit 3*i is the MSB.
  function automatic logic [SYM_W-1:0] card_sym(input logic [0:MAP_W-1] map,
                                                input logic [IDX_W-1:0] idx);
    return map[int'(idx) * SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/card_match_engine_if.sv
// Bundle of map-load, flip request/response and game status signals between
// the front end (master) and the card match engine (slave).
interface card_match_engine_if
  import card_pkg::*;
#(
  parameter int MOVE_W = 8
);

  // flip_valid is a single-cycle request with no ready: the engine answers
  // every request in the following cycle with exactly one of flip_accept or
  // flip_reject; map_load is a single-cycle command that always takes effect.
  logic                   map_load;
  logic [0:MAP_W-1]       map_in;
  logic                   flip_valid;
  logic [IDX_W-1:0]       flip_idx;
  logic                   flip_accept;
  logic                   flip_reject;
  logic [NUM_CARDS-1:0]   face_up;
  logic [NUM_CARDS-1:0]   matched;
  logic [SYM_W-1:0]       sym_a;
  logic [SYM_W-1:0]       sym_b;
  logic                   match_pulse;
  logic                   mismatch_pulse;
  logic [PAIR_W-1:0]      pair_count;
  logic [MOVE_W-1:0]      move_count;
  logic                   game_won;
  logic                   busy;
  card_state_e            state;

  modport master (
    output map_load, map_in, flip_valid, flip_idx,
    input  flip_accept, flip_reject, face_up, matched, sym_a, sym_b,
           match_pulse, mismatch_pulse, pair_count, move_count, game_won,
           busy, state
  );

  modport slave (
    input  map_load, map_in, flip_valid, flip_idx,
    output flip_accept, flip_reject, face_up, matched, sym_a, sym_b,
           match_pulse, mismatch_pulse, pair_count, move_count, game_won,
           busy, state
  );

endinterface

// File: rtl/card_match_engine_hold_timer.sv
// Loadable down-counter that holds a mismatched pair face-up; zero flags expiry.
module hold_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/card_match_engine.sv
// Memory-game engine: latches a 16-card symbol map, takes flips one card at a
// time, compares each revealed pair and tracks matches, moves and the win.
module card_match_engine
  import card_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int MOVE_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  card_match_engine_if.slave  bus
);

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  card_state_e          state_q, state_d;
  logic [0:MAP_W-1]     map_q;
  logic [NUM_CARDS-1:0] face_up_q, matched_q;
  logic [IDX_W-1:0]     idx_a_q, idx_b_q;
  logic [SYM_W-1:0]     sym_a_q, sym_b_q;
  logic [PAIR_W-1:0]    pair_q;
  logic [MOVE_W-1:0]    move_q;
  logic                 accept_q, reject_q, match_q, mismatch_q;

  logic accept_d, reject_d, take_a, take_b;
  logic do_match, do_mismatch, hide_pair, new_game;
  logic timer_load, timer_dec, timer_zero;
  logic flip_legal;

  // Face-up covers matched cards and the pending first card, so one test
  // rejects both re-flips of matched cards and flipping card A twice.
  assign flip_legal = ~face_up_q[bus.flip_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept_d    = 1'b0;
    reject_d    = 1'b0;
    take_a      = 1'b0;
    take_b      = 1'b0;
    do_match    = 1'b0;
    do_mismatch = 1'b0;
    hide_pair   = 1'b0;
    new_game    = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    if (bus.map_load) begin
      new_game = 1'b1;
      reject_d = bus.flip_valid;
      state_d  = WAIT_FIRST;
    end else begin
      unique case (state_q)
        IDLE: begin
          reject_d = bus.flip_valid;
        end
        WAIT_FIRST: begin
          if (bus.flip_valid) begin
            if (flip_legal) begin
              accept_d = 1'b1;
              take_a   = 1'b1;
              state_d  = WAIT_SECOND;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        WAIT_SECOND: begin
          if (bus.flip_valid) begin
            if (flip_legal) begin
              accept_d = 1'b1;
              take_b   = 1'b1;
              state_d  = COMPARE;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        COMPARE: begin
          reject_d = bus.flip_valid;
          if (sym_a_q == sym_b_q) begin
            do_match = 1'b1;
            state_d  = (pair_q == LAST_PAIR) ? WIN : WAIT_FIRST;
          end else begin
            do_mismatch = 1'b1;
            timer_load  = 1'b1;
            state_d     = SHOW;
          end
        end
        SHOW: begin
          reject_d = bus.flip_valid;
          if (timer_zero) begin
            hide_pair = 1'b1;
            state_d   = WAIT_FIRST;
          end else begin
            timer_dec = 1'b1;
          end
        end
        WIN: begin
          reject_d = bus.flip_valid;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_q      <= '0;
      face_up_q  <= '0;
      matched_q  <= '0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      sym_a_q    <= '0;
      sym_b_q    <= '0;
      pair_q     <= '0;
      move_q     <= '0;
      accept_q   <= 1'b0;
      reject_q   <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      accept_q   <= accept_d;
      reject_q   <= reject_d;
      match_q    <= do_match;
      mismatch_q <= do_mismatch;
      if (new_game) begin
        map_q     <= bus.map_in;
        face_up_q <= '0;
        matched_q <= '0;
        idx_a_q   <= '0;
        idx_b_q   <= '0;
        sym_a_q   <= '0;
        sym_b_q   <= '0;
        pair_q    <= '0;
        move_q    <= '0;
      end else begin
        if (take_a) begin
          face_up_q[bus.flip_idx] <= 1'b1;
          idx_a_q                 <= bus.flip_idx;
          sym_a_q                 <= card_sym(map_q, bus.flip_idx);
        end
        if (take_b) begin
          face_up_q[bus.flip_idx] <= 1'b1;
          idx_b_q                 <= bus.flip_idx;
          sym_b_q                 <= card_sym(map_q, bus.flip_idx);
        end
        if ((do_match || do_mismatch) && (move_q != '1)) begin
          move_q <= move_q + 1'b1;
        end
        if (do_match) begin
          matched_q[idx_a_q] <= 1'b1;
          matched_q[idx_b_q] <= 1'b1;
          pair_q             <= pair_q + 1'b1;
        end
        if (hide_pair) begin
          face_up_q[idx_a_q] <= 1'b0;
          face_up_q[idx_b_q] <= 1'b0;
        end
      end
    end
  end

  hold_timer #(
    .WIDTH (TIMER_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (new_game),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (HOLD_LOAD),
    .zero       (timer_zero)
  );

  assign bus.flip_accept    = accept_q;
  assign bus.flip_reject    = reject_q;
  assign bus.face_up        = face_up_q;
  assign bus.matched        = matched_q;
  assign bus.sym_a          = sym_a_q;
  assign bus.sym_b          = sym_b_q;
  assign bus.match_pulse    = match_q;
  assign bus.mismatch_pulse = mismatch_q;
  assign bus.pair_count     = pair_q;
  assign bus.move_count     = move_q;
  assign bus.game_won       = (state_q == WIN);
  assign bus.busy           = (state_q == COMPARE) || (state_q == SHOW);
  assign bus.state          = state_q;

endmodule

// File: tb/tb_card_match_engine.sv
// Directed bench for card_match_engine with a 4-cycle hold; inputs change and
// outputs are sampled on the falling clock edge.
module tb_card_match_engine;
  import card_pkg::*;

  localparam int HOLD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  card_match_engine_if #(.MOVE_W(8)) bus ();

  card_match_engine #(
    .HOLD_CYCLES (HOLD),
    .MOVE_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pairs: (0,5)=6 (1,3)=1 (2,4)=2 (6,7)=0 (8,9)=3 (10,11)=4 (12,13)=5 (14,15)=7
  logic [2:0] sym_tbl [16] = '{3'd6, 3'd1, 3'd2, 3'd1, 3'd2, 3'd6, 3'd0, 3'd0,
                               3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd7, 3'd7};
  logic [3:0] pa_tbl [6] = '{4'd2, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
  logic [3:0] pb_tbl [6] = '{4'd4, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
  logic [0:47] game_map;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flip(input logic [3:0] idx);
    bus.flip_valid = 1'b1;
    bus.flip_idx   = idx;
    @(negedge clk);
    bus.flip_valid = 1'b0;
  endtask

  task automatic load_map();
    bus.map_load = 1'b1;
    bus.map_in   = game_map;
    @(negedge clk);
    bus.map_load = 1'b0;
  endtask

  task automatic play_pair(input logic [3:0] a, input logic [3:0] b);
    flip(a);
    chk("pair_accept_a", 32'(bus.flip_accept), 32'd1);
    flip(b);
    chk("pair_accept_b", 32'(bus.flip_accept), 32'd1);
    @(negedge clk);
    chk("pair_match", 32'(bus.match_pulse), 32'd1);
  endtask

  initial begin
    bus.map_load   = 1'b0;
    bus.map_in     = '0;
    bus.flip_valid = 1'b0;
    bus.flip_idx   = '0;
    for (int i = 0; i < 16; i++) game_map[3*i +: 3] = sym_tbl[i];

    // Reset values and flips with no map loaded
    repeat (2) @(negedge clk);
    chk("rst_face_up", 32'(bus.face_up), 32'h0);
    chk("rst_matched", 32'(bus.matched), 32'h0);
    chk("rst_moves", 32'(bus.move_count), 32'h0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    flip(4'd3);
    chk("idle_reject", 32'(bus.flip_reject), 32'd1);
    chk("idle_accept", 32'(bus.flip_accept), 32'd0);
    chk("idle_face_up", 32'(bus.face_up), 32'h0);
    chk("idle_won", 32'(bus.game_won), 32'd0);

    // First match: cards 0 and 5
    load_map();
    chk("load_state", 32'(bus.state), 32'(WAIT_FIRST));
    flip(4'd0);
    chk("f0_accept", 32'(bus.flip_accept), 32'd1);
    chk("f0_sym_a", 32'(bus.sym_a), 32'd6);
    chk("f0_face_up", 32'(bus.face_up), 32'h0001);
    flip(4'd5);
    chk("f5_accept", 32'(bus.flip_accept), 32'd1);
    chk("f5_state", 32'(bus.state), 32'(COMPARE));
    chk("f5_match_early", 32'(bus.match_pulse), 32'd0);
    @(negedge clk);
    chk("m1_match", 32'(bus.match_pulse), 32'd1);
    chk("m1_matched", 32'(bus.matched), 32'h0021);
    chk("m1_pairs", 32'(bus.pair_count), 32'd1);
    chk("m1_moves", 32'(bus.move_count), 32'd1);

    // Mismatch 1 vs 2, hold for HOLD cycles, flip during SHOW rejected
    flip(4'd1);
    flip(4'd2);
    chk("f2_sym_b", 32'(bus.sym_b), 32'd2);
    @(negedge clk);
    chk("mm_pulse", 32'(bus.mismatch_pulse), 32'd1);
    chk("mm_busy", 32'(bus.busy), 32'd1);
    chk("mm_face_up", 32'(bus.face_up), 32'h0027);
    chk("mm_moves", 32'(bus.move_count), 32'd2);
    flip(4'd7);
    chk("show_reject", 32'(bus.flip_reject), 32'd1);
    chk("show_face_c1", 32'(bus.face_up), 32'h0027);
    @(negedge clk);
    chk("show_face_c2", 32'(bus.face_up), 32'h0027);
    @(negedge clk);
    chk("show_face_c3", 32'(bus.face_up), 32'h0027);
    chk("show_busy_c3", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("show_face_hid", 32'(bus.face_up), 32'h0021);
    chk("show_state_end", 32'(bus.state), 32'(WAIT_FIRST));
    chk("show_busy_end", 32'(bus.busy), 32'd0);

    // Illegal flips: matched card, then card A again as card B
    flip(4'd0);
    chk("rf_matched_rej", 32'(bus.flip_reject), 32'd1);
    chk("rf_matched_st", 32'(bus.state), 32'(WAIT_FIRST));
    flip(4'd1);
    chk("rf_a_accept", 32'(bus.flip_accept), 32'd1);
    flip(4'd1);
    chk("rf_again_rej", 32'(bus.flip_reject), 32'd1);
    chk("rf_again_acc", 32'(bus.flip_accept), 32'd0);
    chk("rf_again_st", 32'(bus.state), 32'(WAIT_SECOND));
    chk("rf_moves", 32'(bus.move_count), 32'd2);
    chk("rf_pairs", 32'(bus.pair_count), 32'd1);
    flip(4'd3);
    @(negedge clk);
    chk("m2_match", 32'(bus.match_pulse), 32'd1);
    chk("m2_matched", 32'(bus.matched), 32'h002B);
    chk("m2_moves", 32'(bus.move_count), 32'd3);

    // Remaining six pairs to a win
    for (int k = 0; k < 6; k++) begin
      play_pair(pa_tbl[k], pb_tbl[k]);
      chk("run_pairs", 32'(bus.pair_count), 32'(k + 3));
    end
    chk("win_won", 32'(bus.game_won), 32'd1);
    chk("win_matched", 32'(bus.matched), 32'hFFFF);
    chk("win_moves", 32'(bus.move_count), 32'd9);
    chk("win_state", 32'(bus.state), 32'(WIN));
    flip(4'd3);
    chk("win_reject", 32'(bus.flip_reject), 32'd1);
    chk("win_pairs", 32'(bus.pair_count), 32'd8);

    // New game, then map_load with a simultaneous flip during SHOW
    load_map();
    chk("ng_won", 32'(bus.game_won), 32'd0);
    flip(4'd0);
    flip(4'd1);
    @(negedge clk);
    chk("ng_mismatch", 32'(bus.mismatch_pulse), 32'd1);
    chk("ng_state_show", 32'(bus.state), 32'(SHOW));
    bus.map_load   = 1'b1;
    bus.map_in     = game_map;
    bus.flip_valid = 1'b1;
    bus.flip_idx   = 4'd2;
    @(negedge clk);
    bus.map_load   = 1'b0;
    bus.flip_valid = 1'b0;
    chk("ml_reject", 32'(bus.flip_reject), 32'd1);
    chk("ml_accept", 32'(bus.flip_accept), 32'd0);
    chk("ml_face_up", 32'(bus.face_up), 32'h0);
    chk("ml_moves", 32'(bus.move_count), 32'd0);
    chk("ml_pairs", 32'(bus.pair_count), 32'd0);
    chk("ml_sym_a", 32'(bus.sym_a), 32'd0);
    chk("ml_state", 32'(bus.state), 32'(WAIT_FIRST));
    chk("ml_busy", 32'(bus.busy), 32'd0);

    // Reset mid-game from WAIT_SECOND
    flip(4'd4);
    chk("rs_pre_state", 32'(bus.state), 32'(WAIT_SECOND));
    chk("rs_pre_face", 32'(bus.face_up), 32'h0010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_face_up", 32'(bus.face_up), 32'h0);
    chk("rs_sym_a", 32'(bus.sym_a), 32'd0);
    chk("rs_accept", 32'(bus.flip_accept), 32'd0);
    chk("rs_state", 32'(bus.state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
